// File: rtl/cuad_decim_capture_pkg.sv
// Shared constants, FSM encoding and helpers for the quadrature decimating capture block.
package cuad_decim_capture_pkg;

  localparam int DATA_IN_W    = 16;
  localparam int DATA_OUT_W   = 32;
  localparam int MAX_DEC_LOG2 = 10;
  localparam int CAPTURE_LEN  = 128;

  localparam int ACC_W  = DATA_IN_W + MAX_DEC_LOG2;
  localparam int DEC_W  = 4;
  localparam int WCNT_W = $clog2(CAPTURE_LEN + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [DEC_W-1:0] clamp_dec(input logic [DEC_W-1:0] d);
    return (d > DEC_W'(MAX_DEC_LOG2)) ? DEC_W'(MAX_DEC_LOG2) : d;
  endfunction

endpackage

// File: rtl/cuad_block_accumulator.sv
// Sums blocks of 2^dec signed samples and registers the floor-mean, sign-extended.
module cuad_block_accumulator
  import cuad_decim_capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_IN_W-1:0]  in_data,
  input  logic [DEC_W-1:0]      dec,
  output logic                  block_end,
  output logic                  sum_valid,
  output logic [DATA_OUT_W-1:0] sum
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  mean;
  logic [MAX_DEC_LOG2-1:0]  cnt;
  logic [MAX_DEC_LOG2-1:0]  cnt_last;

  assign sample_ext = {{MAX_DEC_LOG2{in_data[DATA_IN_W-1]}}, in_data};
  assign acc_next   = acc + sample_ext;
  assign mean       = acc_next >>> dec;
  assign cnt_last   = ~({MAX_DEC_LOG2{1'b1}} << dec);
  // Combinational so the parent can retire the word on the same edge the strobe is registered.
  assign block_end  = in_valid && (cnt == cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (block_end) begin
        acc       <= '0;
        cnt       <= '0;
        sum       <= {{(DATA_OUT_W-ACC_W){mean[ACC_W-1]}}, mean};
        sum_valid <= 1'b1;
      end else if (in_valid) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cuad_decim_capture.sv
// Capture controller: arms on start, counts emitted words and stops at CAPTURE_LEN.
module cuad_decim_capture
  import cuad_decim_capture_pkg::*;
(
  input  logic                  wrclock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DEC_W-1:0]      dec_log2,
  input  logic [DATA_IN_W-1:0]  in_data,
  input  logic                  in_valid,
  output logic [DATA_OUT_W-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]        state;
  logic [WCNT_W-1:0] word_cnt;
  logic [DEC_W-1:0]  dec_q;
  logic              start_ok;
  logic              acc_valid;
  logic              block_end;

  assign start_ok  = start && (state != ST_ACC);
  assign acc_valid = in_valid && (state == ST_ACC);

  cuad_block_accumulator u_acc (
    .clk       (wrclock),
    .rst_n     (reset_n),
    .clear     (start_ok),
    .in_valid  (acc_valid),
    .in_data   (in_data),
    .dec       (dec_q),
    .block_end (block_end),
    .sum_valid (avalonst_source_valid),
    .sum       (avalonst_source_data)
  );

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      dec_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start_ok) begin
      state    <= ST_ACC;
      dec_q    <= clamp_dec(dec_log2);
      word_cnt <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (acc_valid && block_end) begin
      word_cnt <= word_cnt + 1'b1;
      // Final word: status flips together with its strobe.
      if (word_cnt == WCNT_W'(CAPTURE_LEN - 1)) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cuad_decim_capture.sv
// Scoreboarded bench: block-mean reference model feeds a queue, negedge monitor checks strobes and status.
module tb_cuad_decim_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dec_log2 = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] avalonst_source_data;
  logic        avalonst_source_valid;
  logic        busy;
  logic        done;

  cuad_decim_capture dut (
    .wrclock               (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .dec_log2              (dec_log2),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .avalonst_source_data  (avalonst_source_data),
    .avalonst_source_valid (avalonst_source_valid),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  // Reference model: a capture is a list of block means, each block holding 2^dec samples.
  bit     m_active = 0;
  bit     m_done   = 0;
  int     m_dec    = 0;
  int     m_n      = 0;
  int     m_words  = 0;
  longint m_sum    = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic model_edge(bit s, int d, bit v, int x);
    longint n, q;
    if (s && !m_active) begin
      m_active = 1; m_done = 0;
      m_dec = (d > 10) ? 10 : d;
      m_sum = 0; m_n = 0; m_words = 0;
    end else if (m_active && v) begin
      m_sum += x;
      m_n++;
      n = longint'(1) << m_dec;
      if (m_n == n) begin
        q = m_sum / n;
        if ((m_sum % n != 0) && (m_sum < 0)) q = q - 1;
        exp_q.push_back(q[31:0]);
        m_sum = 0; m_n = 0; m_words++;
        if (m_words == 128) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic step(bit s, int d, bit v, int x);
    start = s; dec_log2 = d[3:0]; in_valid = v; in_data = x[15:0];
    @(posedge clk);
    model_edge(s, d, v, x);
    #1;
    start = 0; in_valid = 0;
  endtask

  task automatic drain();
    repeat (3) step(0, 0, 0, 0);
    check("pending_strobes", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    m_active = 0; m_done = 0; m_sum = 0; m_n = 0; m_words = 0;
    exp_q.delete();
    #1;
    check("rst_data", avalonst_source_data, 0);
    check("rst_valid", avalonst_source_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1;
    step(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("busy", busy, m_active);
      check("done", done, m_done);
      if (avalonst_source_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_strobe: got data 0x%0h expected no strobe at %0t", avalonst_source_data, $time);
        end else begin
          check("data", avalonst_source_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    check("init_data", avalonst_source_data, 0);
    check("init_valid", avalonst_source_valid, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    do_reset();

    // Passthrough
    step(1, 0, 0, 0);
    step(0, 0, 1, 5); step(0, 0, 1, -3); step(0, 0, 1, 7);
    drain();
    do_reset();

    // One block of four with gaps
    step(1, 2, 0, 0);
    step(0, 0, 1, 4); step(0, 0, 0, 0); step(0, 0, 1, 8);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, -4);
    step(0, 0, 0, 0); step(0, 0, 1, 12);
    drain();
    do_reset();

    // Floor toward -inf
    step(1, 1, 0, 0);
    step(0, 0, 1, -1); step(0, 0, 1, -2);
    drain();
    do_reset();

    // Clamped exponent: 15 behaves as 10
    step(1, 15, 0, 0);
    for (int i = 0; i < 1024; i++) step(0, 0, 1, -32768);
    drain();
    do_reset();

    // Reset mid-block, then a fresh capture
    step(1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9);
    do_reset();
    step(1, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    drain();
    do_reset();

    // Full capture with overrun and an ignored mid-capture start
    step(1, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      step((i == 50), 3, 1, int'($urandom_range(0, 65535)) - 32768);
    drain();
    check("full_done", done, 1);
    check("full_busy", busy, 0);

    // Restart from DONE
    step(1, 3, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 2);
    drain();
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    do_reset();

    // Randomized captures to completion
    for (int c = 0; c < 3; c++) begin
      int cyc;
      step(1, int'($urandom_range(0, 3)), 0, 0);
      cyc = 0;
      while (m_active && cyc < 20000) begin
        step(($urandom_range(0, 99) == 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)) - 32768);
        cyc++;
      end
      drain();
      check("rand_capture_done", done, 1);
      repeat (int'($urandom_range(0, 5))) step(0, 0, 1, 100);
      drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
